// File: rtl/bounce_pkg.sv
// Shared types and constants for the colour-bounce frame sequencer.
// State encoding, updater command codes and sprite size default.
package bounce_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAW   = 3'd1,
        WAIT   = 3'd2,
        ERASE  = 3'd3,
        UPDATE = 3'd4,
        SETTLE = 3'd5,
        CHECK  = 3'd6,
        OVER   = 3'd7
    } state_e;

    localparam logic [1:0] SIG_IDLE   = 2'b00;
    localparam logic [1:0] SIG_ERASE  = 2'b01;
    localparam logic [1:0] SIG_DRAW   = 2'b10;
    localparam logic [1:0] SIG_UPDATE = 2'b11;

    localparam int BALL_DIM_DEFAULT = 4;

endpackage

// File: rtl/bounce_frame_sequencer_tick.sv
// Free-running frame counter with enable, freeze and synchronous clear.
// wrap is a 1-cycle pulse on the last count of each frame.
module frame_tick_gen #(
    parameter int FRAME_TICKS = 833333
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic freeze,
    input  logic clear,
    output logic wrap
);

    localparam int CW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_TICKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        wrap  = en && !freeze && !clear && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en && !freeze) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/bounce_frame_sequencer.sv
// Frame-level controller: erase, update, check, draw, then wait for the next tick.
// Define BOUNCE_PAUSE_EN to let pause_sw hold the sequencer in WAIT.
module bounce_frame_sequencer
    import bounce_pkg::*;
#(
    parameter int FRAME_TICKS = 833333,
    parameter int BALL_DIM    = BALL_DIM_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause_sw,
    input  logic       gameover,
    output logic [1:0] statesig,
    output logic       plot,
    output logic       erase,
    output logic [1:0] px_off,
    output logic [1:0] py_off,
    output logic       game_active,
    output logic       game_over,
    output logic [7:0] frame_miss
);

    localparam logic [1:0] LAST_OFF = 2'(BALL_DIM - 1);

    state_e     state_q, state_d;
    logic [1:0] px_q, px_d, py_q, py_d;
    logic       pending_q, pending_d;
    logic [7:0] miss_q, miss_d;
    logic [1:0] sig_q, sig_d;
    logic       plot_q, plot_d;
    logic       erase_q, erase_d;
    logic       active_q, active_d;
    logic       over_q, over_d;
    logic       clear, leave_wait, wrap, pause_hold;

`ifdef BOUNCE_PAUSE_EN
    assign pause_hold = (state_q == WAIT) && pause_sw;
`else
    logic unused_pause;
    assign unused_pause = pause_sw;
    assign pause_hold   = 1'b0;
`endif

    frame_tick_gen #(
        .FRAME_TICKS(FRAME_TICKS)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (active_q),
        .freeze(pause_hold),
        .clear (clear),
        .wrap  (wrap)
    );

    always_comb begin
        state_d    = state_q;
        px_d       = 2'd0;
        py_d       = 2'd0;
        clear      = 1'b0;
        leave_wait = 1'b0;
        unique case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d = DRAW;
                    clear   = 1'b1;
                end
            end
            DRAW, ERASE: begin
                if (px_q == LAST_OFF) begin
                    if (py_q == LAST_OFF) begin
                        state_d = (state_q == DRAW) ? WAIT : UPDATE;
                    end else begin
                        py_d = py_q + 2'd1;
                    end
                end else begin
                    px_d = px_q + 2'd1;
                    py_d = py_q;
                end
            end
            WAIT: begin
                if (!pause_hold && pending_q) begin
                    state_d    = ERASE;
                    leave_wait = 1'b1;
                end
            end
            UPDATE:  state_d = SETTLE;
            SETTLE:  state_d = CHECK;
            CHECK:   state_d = gameover ? OVER : DRAW;
            default: state_d = IDLE;
        endcase
    end

    // A wrap that lands while the previous tick is unconsumed is a dropped frame.
    always_comb begin
        pending_d = pending_q;
        miss_d    = miss_q;
        if (leave_wait) pending_d = 1'b0;
        if (wrap) begin
            if (pending_q && !leave_wait && miss_q != 8'hFF) begin
                miss_d = miss_q + 8'd1;
            end
            pending_d = 1'b1;
        end
        if (clear) pending_d = 1'b0;
    end

    always_comb begin
        sig_d    = SIG_IDLE;
        plot_d   = 1'b0;
        erase_d  = 1'b0;
        active_d = (state_d != IDLE) && (state_d != OVER);
        over_d   = (state_d == OVER);
        unique case (state_d)
            ERASE: begin
                sig_d   = SIG_ERASE;
                plot_d  = 1'b1;
                erase_d = 1'b1;
            end
            DRAW: begin
                sig_d  = SIG_DRAW;
                plot_d = 1'b1;
            end
            UPDATE:  sig_d = SIG_UPDATE;
            default: sig_d = SIG_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            px_q      <= 2'd0;
            py_q      <= 2'd0;
            pending_q <= 1'b0;
            miss_q    <= 8'd0;
            sig_q     <= SIG_IDLE;
            plot_q    <= 1'b0;
            erase_q   <= 1'b0;
            active_q  <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            px_q      <= px_d;
            py_q      <= py_d;
            pending_q <= pending_d;
            miss_q    <= miss_d;
            sig_q     <= sig_d;
            plot_q    <= plot_d;
            erase_q   <= erase_d;
            active_q  <= active_d;
            over_q    <= over_d;
        end
    end

    assign statesig    = sig_q;
    assign plot        = plot_q;
    assign erase       = erase_q;
    assign px_off      = px_q;
    assign py_off      = py_q;
    assign game_active = active_q;
    assign game_over   = over_q;
    assign frame_miss  = miss_q;

endmodule

// File: tb/tb_bounce_frame_sequencer.sv
// Scoreboard bench for bounce_frame_sequencer (FRAME_TICKS=40, BALL_DIM=4).
// A second instance with a short frame exercises dropped-frame counting.
module tb_bounce_frame_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1, start = 1'b0, pause_sw = 1'b0, gameover = 1'b0;
    logic [1:0] a_sig, a_px, a_py;
    logic       a_plot, a_erase, a_active, a_over;
    logic [7:0] a_miss;

    logic       reset_b = 1'b1, start_b = 1'b0;
    logic       pause_b = 1'b0, gameover_b = 1'b0;
    logic [1:0] b_sig, b_px, b_py;
    logic       b_plot, b_erase, b_active, b_over;
    logic [7:0] b_miss;

    bounce_frame_sequencer #(.FRAME_TICKS(40), .BALL_DIM(4)) u_dut (
        .clk(clk), .reset(reset), .start(start), .pause_sw(pause_sw),
        .gameover(gameover), .statesig(a_sig), .plot(a_plot),
        .erase(a_erase), .px_off(a_px), .py_off(a_py),
        .game_active(a_active), .game_over(a_over), .frame_miss(a_miss)
    );

    // Frame shorter than the 35-cycle work budget, so ticks get dropped.
    bounce_frame_sequencer #(.FRAME_TICKS(20), .BALL_DIM(4)) u_ovr (
        .clk(clk), .reset(reset_b), .start(start_b), .pause_sw(pause_b),
        .gameover(gameover_b), .statesig(b_sig), .plot(b_plot),
        .erase(b_erase), .px_off(b_px), .py_off(b_py),
        .game_active(b_active), .game_over(b_over), .frame_miss(b_miss)
    );

    logic [6:0] obs_a;
    assign obs_a = {a_plot, a_erase, a_px, a_py, a_sig};

    logic [6:0] exp_q[$];
    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [6:0] pk(input logic p, input logic e,
                                      input logic [1:0] x, input logic [1:0] y,
                                      input logic [1:0] s);
        return {p, e, x, y, s};
    endfunction

    task automatic push_walk(input logic er);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                exp_q.push_back(pk(1'b1, er, 2'(x), 2'(y),
                                   er ? 2'b01 : 2'b10));
    endtask

    task automatic drain(input string tag, input int n);
        logic [6:0] e;
        for (int i = 0; i < n; i++) begin
            if (i > 0) tick();
            e = exp_q.pop_front();
            check_eq($sformatf("%s[%0d]", tag, i), 32'(obs_a), 32'(e));
            gameover = a_plot;
        end
    endtask

    task automatic wait_erase(input int exp_cyc);
        int n = 0;
        while (a_sig != 2'b01 && n < 100) begin
            tick();
            n++;
        end
        check_eq("erase_start_cycle", 32'(cyc), 32'(exp_cyc));
    endtask

    task automatic run_frame(input int exp_cyc);
        wait_erase(exp_cyc);
        push_walk(1'b1);
        exp_q.push_back(pk(1'b0, 1'b0, 2'd0, 2'd0, 2'b11));
        exp_q.push_back(7'd0);
        exp_q.push_back(7'd0);
        push_walk(1'b0);
        exp_q.push_back(7'd0);
        drain("frame", 36);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c0, ee, prev, n;
        logic bad, seen;

        repeat (3) tick();
        check_eq("reset_outputs",
                 32'({obs_a, a_active, a_over, a_miss}), 32'd0);

        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        c0 = cyc;
        push_walk(1'b0);
        drain("draw0", 16);
        tick();
        check_eq("wait_idle_out", 32'(obs_a), 32'd0);
        check_eq("active_in_wait", 32'(a_active), 32'd1);

        ee = c0 + 41;
        for (int f = 0; f < 3; f++) begin
            run_frame(ee);
            ee += 40;
        end
        check_eq("no_miss_free_run", 32'(a_miss), 32'd0);

        wait_erase(ee);
        push_walk(1'b1);
        exp_q.push_back(pk(1'b0, 1'b0, 2'd0, 2'd0, 2'b11));
        exp_q.push_back(7'd0);
        drain("to_settle", 18);
        gameover = 1'b1;
        tick();
        check_eq("gameover_ignored_in_settle", 32'(a_active), 32'd1);
        tick();
        gameover = 1'b0;
        check_eq("over_flag", 32'(a_over), 32'd1);
        check_eq("over_inactive", 32'(a_active), 32'd0);
        check_eq("over_outputs", 32'(obs_a), 32'd0);
        repeat (50) tick();
        check_eq("over_holds", 32'({a_over, obs_a}), 32'h80);

        start = 1'b1;
        tick();
        start = 1'b0;
        c0 = cyc;
        push_walk(1'b0);
        drain("draw_restart", 16);
        wait_erase(c0 + 41);

        repeat (6) tick();
        check_eq("seventh_erase_plot", 32'(obs_a),
                 32'(pk(1'b1, 1'b1, 2'd2, 2'd1, 2'b01)));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        gameover = 1'b0;
        check_eq("reset_mid_sprite",
                 32'({obs_a, a_active, a_over, a_miss}), 32'd0);
        repeat (5) tick();
        check_eq("idle_after_reset", 32'({obs_a, a_active}), 32'd0);

`ifdef BOUNCE_PAUSE_EN
        start = 1'b1;
        tick();
        start = 1'b0;
        c0 = cyc;
        push_walk(1'b0);
        drain("draw_pause", 16);
        while (cyc < c0 + 40) tick();
        check_eq("pause_wait_state", 32'({a_active, obs_a}), 32'h80);
        pause_sw = 1'b1;
        seen = 1'b0;
        repeat (200) begin
            tick();
            if (a_sig == 2'b11 || a_plot) seen = 1'b1;
        end
        check_eq("pause_no_update", 32'(seen), 32'd0);
        check_eq("pause_no_miss", 32'(a_miss), 32'd0);
        pause_sw = 1'b0;
        tick();
        check_eq("release_to_erase", 32'(a_sig), 32'd1);
`endif

        reset_b = 1'b0;
        tick();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        c0 = cyc;
        while (cyc < c0 + 79) tick();
        check_eq("ovr_no_miss_yet", 32'(b_miss), 32'd0);
        tick();
        check_eq("ovr_first_miss", 32'(b_miss), 32'd1);
        bad = 1'b0;
        n = 0;
        while (b_miss != 8'hFF && n < 30000) begin
            prev = int'(b_miss);
            tick();
            n++;
            if (int'(b_miss) < prev || int'(b_miss) > prev + 1) bad = 1'b1;
        end
        check_eq("ovr_saturate_reached", 32'(b_miss), 32'hFF);
        repeat (200) begin
            tick();
            if (b_miss != 8'hFF) bad = 1'b1;
        end
        check_eq("ovr_step_and_hold", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errs);
        $finish;
    end

endmodule
